lsu_axi_master: RTL and testbench
=================================

// Module: lsu_axi_master
// PURPOSE
//  Memory-side half of load/store: accepts one load/store request per handshake from EXU,
//  aligns store data/strobes, drives an AXI4-Lite master port, and returns the read word
//  shifted so byte 0 of the access sits at bit 0 (WBU sign/zero-extends per func3).
//  Sits between EXU and WBU; the only block in the core issuing data-memory transactions.
// PARAMETERS
//  ADDR_W  32  address width (araddr/awaddr)
//  DATA_W  32  data width; fixed at 32, strobe width DATA_W/8
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   asynchronous active-low reset
//  in_valid      in   1   EXU request valid
//  in_ready      out  1   block can accept a request
//  MemRead       in   1   request is a load
//  MemWrite      in   1   request is a store
//  func3         in   3   access size/sign (000 b,001 h,010 w,100 bu,101 hu)
//  addr          in   32  byte address of access
//  store_data    in   32  rs2 value, unaligned (data in low bytes)
//  out_valid     out  1   result valid to WBU
//  out_ready     in   1   WBU accepts result
//  mem_rdata     out  32  read word shifted right by 8*addr[1:0]; 0 for stores/non-mem
//  access_fault  out  1   bus returned non-OKAY resp
//  misaligned    out  1   access not naturally aligned; no bus transaction issued
//  araddr/arvalid/arready, rdata/rresp/rvalid/rready   AXI4-Lite read channels
//  awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready   write channels
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all valid/ready outputs 0 except in_ready=1 after
//    release; mem_rdata, access_fault, misaligned, captured regs = 0. Reset mid-transaction
//    abandons it; bus valids drop immediately, no completion reported.
//  - States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE. in_ready = (state==IDLE).
//  - IDLE: on in_valid&in_ready capture addr/func3/data/type. MemWrite wins if both set.
//    Misaligned (h with addr[0]=1, w with addr[1:0]!=0) or neither MemRead/MemWrite ->
//    DONE, no bus activity, misaligned set accordingly. Load -> RD_ADDR; store -> WR.
//  - RD_ADDR: arvalid=1, araddr=addr (unmodified); hold stable until arready -> RD_DATA.
//  - RD_DATA: rready=1; on rvalid latch mem_rdata=rdata>>(8*addr[1:0]),
//    access_fault=(rresp!=0) -> DONE.
//  - WR: awvalid and wvalid both rise on entry; each drops the cycle after its own
//    handshake; order of aw/w completion free, including same cycle. Both done -> WR_RESP.
//    wdata=store_data<<(8*addr[1:0]); wstrb: b 4'b0001<<addr[1:0], h 4'b0011<<addr[1:0],
//    w 4'b1111. awaddr=addr.
//  - WR_RESP: bready=1; on bvalid access_fault=(bresp!=0) -> DONE.
//  - DONE: out_valid=1, outputs stable until out_ready -> IDLE; next request accepted
//    the cycle after (no same-cycle turnaround). Minimum latency: accept->out_valid 3
//    cycles for load with zero-wait slave, 1 cycle for non-mem/misaligned.
//  - Flags (access_fault, misaligned, mem_rdata) cleared on each new accept.
//  - All AXI outputs held stable while valid and not yet accepted (AXI rule).
// TESTING
//  1 sb addr=0x80000003 data=0x000000AB -> awaddr 0x80000003, wdata 0xAB000000,
//    wstrb 4'b1000; bresp=0 -> out_valid, access_fault=0.
//  2 lh addr=0x80000102, slave rdata=0x80011234 -> mem_rdata 0x00008001, misaligned=0.
//  3 sw addr=0x80000002 -> no arvalid/awvalid ever, out_valid 1 cycle later, misaligned=1.
//  4 sw, wready=1 immediately, awready after 3 cycles -> wvalid high 1 cycle, awvalid 4
//    cycles, exactly one bready handshake, single out_valid.
//  5 lw, rresp=2'b10, rdata=0xDEADBEEF -> access_fault=1, mem_rdata 0xDEADBEEF.
//  6 rst low during RD_DATA -> arvalid/rready/out_valid 0 same cycle; after release
//    in_ready=1, new lw completes normally; out_ready held 0 in DONE keeps outputs stable.

Source files
------------

// File: rtl/lsu_axi_master_if.sv
// Bundle of the signals between the LSU memory stage and its neighbours.
// Groups the EXU request, the WBU result and the AXI4-Lite master channels.
// The master modport is the LSU's view; the slave modport is the view of
// the environment around it (EXU/WBU and the memory slave).
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // EXU request
  logic                  in_valid;
  logic                  in_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            func3;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     store_data;
  // WBU result
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  access_fault;
  logic                  misaligned;
  // AXI4-Lite read address / read data
  logic [ADDR_W-1:0]     araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  // AXI4-Lite write address / write data / write response
  logic [ADDR_W-1:0]     awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    input  in_valid, MemRead, MemWrite, func3, addr, store_data,
    output in_ready,
    output out_valid, mem_rdata, access_fault, misaligned,
    input  out_ready,
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    output in_valid, MemRead, MemWrite, func3, addr, store_data,
    input  in_ready,
    input  out_valid, mem_rdata, access_fault, misaligned,
    output out_ready,
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_axi_master.sv
// Memory-side half of load/store. Takes one request at a time from EXU,
// issues a single AXI4-Lite read or write (or none, for misaligned and
// non-memory requests) and hands the result to WBU. Load data is returned
// shifted so the addressed byte sits at bit 0; extension happens in WBU.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  lsu_axi_master_if.master   bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_WR_RESP,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                out_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic                access_fault_q;
  logic                misaligned_q;

  logic                is_byte;
  logic                is_half;
  logic                req_misaligned;
  logic [STRB_W-1:0]   wstrb_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W-1:0]   rdata_aligned;
  logic                accept;
  logic                aw_fin;
  logic                w_fin;

  assign accept = bus.in_valid && in_ready_q;

  // Decode access size from func3 and derive alignment, strobe and lane-shifted store data
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    case (bus.func3)
      3'b000, 3'b100: is_byte = 1'b1;
      3'b001, 3'b101: is_half = 1'b1;
      default:        ;  // everything else is treated as a word access
    endcase
    if (is_byte) begin
      req_misaligned = 1'b0;
      wstrb_d        = {{(STRB_W-1){1'b0}}, 1'b1} << bus.addr[1:0];
    end else if (is_half) begin
      req_misaligned = bus.addr[0];
      wstrb_d        = {{(STRB_W-2){1'b0}}, 2'b11} << bus.addr[1:0];
    end else begin
      req_misaligned = (bus.addr[1:0] != 2'b00);
      wstrb_d        = '1;
    end
    wdata_d = bus.store_data << {bus.addr[1:0], 3'b000};
  end

  // Read word shifted so the addressed byte lands in lane 0; upper lanes fill with zero
  assign rdata_aligned = bus.rdata >> {addr_q[1:0], 3'b000};

  // A write channel counts as finished once it was accepted earlier or is accepted now
  assign aw_fin = !awvalid_q || bus.awready;
  assign w_fin  = !wvalid_q  || bus.wready;

  // Transaction FSM; every handshake output is a register so the bus sees glitch-free, stable values
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      mem_rdata_q    <= '0;
      access_fault_q <= 1'b0;
      misaligned_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q     <= 1'b0;
            addr_q         <= bus.addr;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            mem_rdata_q    <= '0;
            access_fault_q <= 1'b0;
            misaligned_q   <= 1'b0;
            if ((bus.MemWrite || bus.MemRead) && req_misaligned) begin
              // Report straight away; nothing goes out on the bus
              misaligned_q <= 1'b1;
              out_valid_q  <= 1'b1;
              state_q      <= S_DONE;
            end else if (bus.MemWrite) begin
              // Store takes priority when both request types are flagged
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR;
            end else if (bus.MemRead) begin
              arvalid_q <= 1'b1;
              state_q   <= S_RD_ADDR;
            end else begin
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_RD_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (bus.rvalid) begin
            rready_q       <= 1'b0;
            mem_rdata_q    <= rdata_aligned;
            access_fault_q <= (bus.rresp != 2'b00);
            out_valid_q    <= 1'b1;
            state_q        <= S_DONE;
          end
        end
        S_WR: begin
          // Address and data channels complete independently, in either order
          if (awvalid_q && bus.awready) awvalid_q <= 1'b0;
          if (wvalid_q && bus.wready)   wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bus.bvalid) begin
            bready_q       <= 1'b0;
            access_fault_q <= (bus.bresp != 2'b00);
            out_valid_q    <= 1'b1;
            state_q        <= S_DONE;
          end
        end
        S_DONE: begin
          // in_ready rises with the return to IDLE, so a new request is taken the cycle after
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.access_fault = access_fault_q;
  assign bus.misaligned   = misaligned_q;
  assign bus.araddr       = addr_q;
  assign bus.arvalid      = arvalid_q;
  assign bus.rready       = rready_q;
  assign bus.awaddr       = addr_q;
  assign bus.awvalid      = awvalid_q;
  assign bus.wdata        = wdata_q;
  assign bus.wstrb        = wstrb_q;
  assign bus.wvalid       = wvalid_q;
  assign bus.bready       = bready_q;
endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: a configurable AXI4-Lite slave responder,
// a bus activity monitor and a scoreboard of expected WBU results.
module tb_lsu_axi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_axi_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    int          kind;   // 0 no bus access, 1 read, 2 write
    logic [31:0] rdata;
    logic        fault;
    logic        misal;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;    // 0 = latency not checked
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // slave behaviour knobs
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic [1:0]  slv_rresp = 2'b00;
  logic [1:0]  slv_bresp = 2'b00;

  // slave captures and monitor counters
  logic [31:0] cap_araddr = 32'h0, cap_awaddr = 32'h0, cap_wdata = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0;
  int ar_cyc = 0, aw_cyc = 0, w_cyc = 0, b_hs = 0, ov_rise = 0;

  task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // AR channel: accept after ar_dly waiting cycles, check address held while waiting
  initial begin
    int cnt;
    logic [31:0] first;
    cnt = 0; first = 32'h0; bus.arready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin bus.arready = 1'b0; cnt = 0; end
      else if (bus.arready) bus.arready = 1'b0;
      else if (bus.arvalid) begin
        if (cnt == 0) first = bus.araddr;
        if (cnt >= ar_dly) begin
          if (cnt > 0) tb_check("araddr_stable", bus.araddr, first);
          cap_araddr = bus.araddr; bus.arready = 1'b1; cnt = 0;
        end else cnt++;
      end
    end
  end

  // R channel: return slv_rdata/slv_rresp r_dly cycles after rready
  initial begin
    int cnt;
    cnt = 0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin bus.rvalid = 1'b0; cnt = 0; end
      else if (bus.rvalid) bus.rvalid = 1'b0;
      else if (bus.rready) begin
        if (cnt >= r_dly) begin
          bus.rvalid = 1'b1; bus.rdata = slv_rdata; bus.rresp = slv_rresp; cnt = 0;
        end else cnt++;
      end
    end
  end

  // AW channel
  initial begin
    int cnt;
    logic [31:0] first;
    cnt = 0; first = 32'h0; bus.awready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin bus.awready = 1'b0; cnt = 0; end
      else if (bus.awready) bus.awready = 1'b0;
      else if (bus.awvalid) begin
        if (cnt == 0) first = bus.awaddr;
        if (cnt >= aw_dly) begin
          if (cnt > 0) tb_check("awaddr_stable", bus.awaddr, first);
          cap_awaddr = bus.awaddr; bus.awready = 1'b1; cnt = 0;
        end else cnt++;
      end
    end
  end

  // W channel
  initial begin
    int cnt;
    logic [31:0] first;
    cnt = 0; first = 32'h0; bus.wready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin bus.wready = 1'b0; cnt = 0; end
      else if (bus.wready) bus.wready = 1'b0;
      else if (bus.wvalid) begin
        if (cnt == 0) first = bus.wdata;
        if (cnt >= w_dly) begin
          if (cnt > 0) tb_check("wdata_stable", bus.wdata, first);
          cap_wdata = bus.wdata; cap_wstrb = bus.wstrb; bus.wready = 1'b1; cnt = 0;
        end else cnt++;
      end
    end
  end

  // B channel: respond b_dly cycles after bready, count completed handshakes
  initial begin
    int cnt;
    cnt = 0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin bus.bvalid = 1'b0; cnt = 0; end
      else if (bus.bvalid) begin bus.bvalid = 1'b0; b_hs++; end
      else if (bus.bready) begin
        if (cnt >= b_dly) begin bus.bvalid = 1'b1; bus.bresp = slv_bresp; cnt = 0; end
        else cnt++;
      end
    end
  end

  // Activity monitor
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.arvalid) ar_cyc++;
      if (bus.awvalid) aw_cyc++;
      if (bus.wvalid)  w_cyc++;
      if (bus.out_valid && !prev) ov_rise++;
      prev = bus.out_valid;
    end
  end

  function automatic exp_t mk_exp(input string tag, input int kind, input logic [31:0] rdata,
                                  input logic fault, input logic misal, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb, input int lat);
    exp_t e;
    e.tag = tag; e.kind = kind; e.rdata = rdata; e.fault = fault; e.misal = misal;
    e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.lat = lat;
    return e;
  endfunction

  // Reference model: byte-lane view of the expected result
  function automatic exp_t model_exp(input string tag, input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] sd, input logic [31:0] rword,
                                     input logic [1:0] rresp, input logic [1:0] bresp);
    exp_t e;
    int sz;
    int off;
    e = mk_exp(tag, 0, 32'h0, 1'b0, 1'b0, a, 32'h0, 4'h0, 0);
    off = int'(a[1:0]);
    case (f3[1:0])
      2'b00:   sz = 1;
      2'b01:   sz = 2;
      default: sz = 4;
    endcase
    if ((rd || wr) && ((sz == 2 && a[0]) || (sz == 4 && off != 0))) begin
      e.misal = 1'b1; e.lat = 1;
    end else if (wr) begin
      e.kind = 2; e.fault = (bresp != 2'b00);
      for (int i = 0; i < 4; i++) begin
        if (i >= off) e.wdata[8*i +: 8] = sd[8*(i-off) +: 8];
        if (i >= off && i < off + sz) e.wstrb[i] = 1'b1;
      end
    end else if (rd) begin
      e.kind = 1; e.fault = (rresp != 2'b00);
      for (int i = 0; i < 4; i++)
        if (i + off < 4) e.rdata[8*i +: 8] = rword[8*(i+off) +: 8];
    end else begin
      e.lat = 1;
    end
    return e;
  endfunction

  // Drive one request, wait for its result, compare against the scoreboard head
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input exp_t e,
                         input int hold);
    int n;
    int ar0;
    int aw0;
    exp_t x;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!bus.in_ready) begin
      tb_check({e.tag, "_in_ready_timeout"}, 32'(bus.in_ready), 32'h1);
      return;
    end
    ar0 = ar_cyc; aw0 = aw_cyc;
    bus.out_ready  = (hold == 0);
    bus.in_valid   = 1'b1;
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.func3      = f3;
    bus.addr       = a;
    bus.store_data = sd;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk); #1;
      bus.in_valid = 1'b0;
      n++;
    end while (!bus.out_valid && n < 200);
    x = sb_q.pop_front();
    if (!bus.out_valid) begin
      tb_check({x.tag, "_out_valid_timeout"}, 32'(bus.out_valid), 32'h1);
      return;
    end
    tb_check({x.tag, "_rdata"}, bus.mem_rdata, x.rdata);
    tb_check({x.tag, "_fault"}, 32'(bus.access_fault), 32'(x.fault));
    tb_check({x.tag, "_misal"}, 32'(bus.misaligned), 32'(x.misal));
    if (x.lat > 0) tb_check({x.tag, "_latency"}, 32'(n), 32'(x.lat));
    case (x.kind)
      2: begin
        tb_check({x.tag, "_awaddr"}, cap_awaddr, x.addr);
        tb_check({x.tag, "_wdata"}, cap_wdata, x.wdata);
        tb_check({x.tag, "_wstrb"}, 32'(cap_wstrb), 32'(x.wstrb));
        tb_check({x.tag, "_no_ar"}, 32'(ar_cyc - ar0), 32'h0);
      end
      1: begin
        tb_check({x.tag, "_araddr"}, cap_araddr, x.addr);
        tb_check({x.tag, "_no_aw"}, 32'(aw_cyc - aw0), 32'h0);
      end
      default: tb_check({x.tag, "_no_bus"}, 32'((ar_cyc - ar0) + (aw_cyc - aw0)), 32'h0);
    endcase
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      tb_check({x.tag, "_hold_valid"}, 32'(bus.out_valid), 32'h1);
      tb_check({x.tag, "_hold_rdata"}, bus.mem_rdata, x.rdata);
    end
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    tb_check({x.tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'h0);
    tb_check({x.tag, "_in_ready_back"}, 32'(bus.in_ready), 32'h1);
    $display("[TB] txn %s: rdata=0x%08h fault=%0b misal=%0b cycles=%0d",
             x.tag, x.rdata, x.fault, x.misal, n);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int aw0, w0, b0, ov0, n;
    logic [31:0] sd;
    bus.in_valid = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.func3 = 3'b000;
    bus.addr = 32'h0; bus.store_data = 32'h0; bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    tb_check("rst_arvalid", 32'(bus.arvalid), 32'h0);
    tb_check("rst_awvalid", 32'(bus.awvalid), 32'h0);
    tb_check("rst_wvalid", 32'(bus.wvalid), 32'h0);
    tb_check("rst_rready", 32'(bus.rready), 32'h0);
    tb_check("rst_bready", 32'(bus.bready), 32'h0);
    tb_check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    tb_check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    tb_check("rst_flags", 32'({bus.access_fault, bus.misaligned}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    tb_check("rst_in_ready_after", 32'(bus.in_ready), 32'h1);

    // 1: sb to byte 3
    run_txn(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB,
            mk_exp("sb_off3", 2, 32'h0, 1'b0, 1'b0, 32'h8000_0003, 32'hAB00_0000, 4'b1000, 0), 0);

    // 2: lh upper half, zero-wait slave
    slv_rdata = 32'h8001_1234;
    run_txn(1'b1, 1'b0, 3'b001, 32'h8000_0102, 32'h0,
            mk_exp("lh_off2", 1, 32'h0000_8001, 1'b0, 1'b0, 32'h8000_0102, 32'h0, 4'h0, 3), 0);

    // 3: misaligned sw
    run_txn(1'b0, 1'b1, 3'b010, 32'h8000_0002, 32'h1111_2222,
            mk_exp("sw_misal", 0, 32'h0, 1'b0, 1'b1, 32'h8000_0002, 32'h0, 4'h0, 1), 0);

    // 4: sw with awready 3 cycles late, wready immediate
    aw_dly = 3;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs; ov0 = ov_rise;
    run_txn(1'b0, 1'b1, 3'b010, 32'h8000_0020, 32'h1234_5678,
            mk_exp("sw_aw_late", 2, 32'h0, 1'b0, 1'b0, 32'h8000_0020, 32'h1234_5678, 4'hF, 0), 0);
    tb_check("sw_aw_late_awvalid_cycles", 32'(aw_cyc - aw0), 32'd4);
    tb_check("sw_aw_late_wvalid_cycles", 32'(w_cyc - w0), 32'd1);
    tb_check("sw_aw_late_b_handshakes", 32'(b_hs - b0), 32'd1);
    tb_check("sw_aw_late_out_pulses", 32'(ov_rise - ov0), 32'd1);
    aw_dly = 0;

    // 5: lw with SLVERR
    slv_rdata = 32'hDEAD_BEEF; slv_rresp = 2'b10;
    run_txn(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0,
            mk_exp("lw_slverr", 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0), 0);
    slv_rresp = 2'b00;

    // store error response, data channel late, both-type request, non-memory, misaligned lh
    slv_bresp = 2'b11; w_dly = 2; b_dly = 1;
    run_txn(1'b0, 1'b1, 3'b010, 32'h8000_0040, 32'hA5A5_0F0F,
            model_exp("sw_decerr", 1'b0, 1'b1, 3'b010, 32'h8000_0040, 32'hA5A5_0F0F, 32'h0, 2'b00, 2'b11), 0);
    slv_bresp = 2'b00; w_dly = 0; b_dly = 0;
    run_txn(1'b1, 1'b1, 3'b001, 32'h8000_0052, 32'h0000_BEEF,
            mk_exp("rw_both_sh", 2, 32'h0, 1'b0, 1'b0, 32'h8000_0052, 32'hBEEF_0000, 4'b1100, 0), 0);
    run_txn(1'b0, 1'b0, 3'b010, 32'h8000_0061, 32'h0,
            mk_exp("non_mem", 0, 32'h0, 1'b0, 1'b0, 32'h8000_0061, 32'h0, 4'h0, 1), 0);
    run_txn(1'b1, 1'b0, 3'b101, 32'h8000_0071, 32'h0,
            model_exp("lhu_misal", 1'b1, 1'b0, 3'b101, 32'h8000_0071, 32'h0, 32'h0, 2'b00, 2'b00), 0);

    // byte loads and stores across every lane
    slv_rdata = 32'h4433_2211; r_dly = 1;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b0, 3'b100, 32'h8000_0200 + 32'(i), 32'h0,
              model_exp($sformatf("lbu_off%0d", i), 1'b1, 1'b0, 3'b100, 32'h8000_0200 + 32'(i),
                        32'h0, 32'h4433_2211, 2'b00, 2'b00), 0);
    end
    r_dly = 0;
    for (int i = 0; i < 4; i++) begin
      sd = $urandom;
      run_txn(1'b0, 1'b1, 3'b000, 32'h8000_0300 + 32'(i), sd,
              model_exp($sformatf("sb_lane%0d", i), 1'b0, 1'b1, 3'b000, 32'h8000_0300 + 32'(i),
                        sd, 32'h0, 2'b00, 2'b00), 0);
    end

    // 6: reset while waiting for read data
    r_dly = 20;
    bus.in_valid = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
    bus.func3 = 3'b010; bus.addr = 32'h8000_0400;
    n = 0;
    do begin
      @(negedge clk); #1;
      bus.in_valid = 1'b0;
      n++;
    end while (!bus.rready && n < 30);
    tb_check("rst_mid_reached_rd_data", 32'(bus.rready), 32'h1);
    rst_n = 1'b0;
    #1;
    tb_check("rst_mid_arvalid", 32'(bus.arvalid), 32'h0);
    tb_check("rst_mid_rready", 32'(bus.rready), 32'h0);
    tb_check("rst_mid_out_valid", 32'(bus.out_valid), 32'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    r_dly = 0;
    @(negedge clk); #1;
    tb_check("rst_mid_in_ready", 32'(bus.in_ready), 32'h1);
    tb_check("rst_mid_no_result", 32'(bus.out_valid), 32'h0);
    slv_rdata = 32'hCAFE_F00D;
    run_txn(1'b1, 1'b0, 3'b010, 32'h8000_0404, 32'h0,
            mk_exp("lw_after_rst_hold", 1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h8000_0404, 32'h0, 4'h0, 3), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
